// File: rtl/shift_seq_unit_pkg.sv
// Shared types for the shift/step sequencer.
// State codes double as the regime status field; mode codes match the on input.
package shift_seq_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    M_SHL = 2'b00,
    M_SHR = 2'b01,
    M_ROL = 2'b10,
    M_ASR = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_seq_unit_dp.sv
// Datapath: y/s/b registers, shift/rotate mux and step counter.
// Ports: clk, rst (async low), load_en, step_en, mode, x, n -> y, s, b, last.
module shift_seq_unit_dp
  import shift_seq_unit_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          step_en,
  input  mode_e         mode,
  input  logic [W-1:0]  x,
  input  logic [SW-1:0] n,
  output logic [W-1:0]  y,
  output logic [SW-1:0] s,
  output logic          b,
  output logic          last
);

  localparam logic [SW-1:0] ONE = SW'(1);

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] s_q, s_d;
  logic          b_q, b_d;

  // s stays below n, so s+1 never wraps
  assign last = (s_q + ONE) == n;

  always_comb begin
    y_d = y_q;
    s_d = s_q;
    b_d = b_q;
    if (load_en) begin
      y_d = x;
      s_d = '0;
      b_d = 1'b0;
    end else if (step_en) begin
      s_d = s_q + ONE;
      unique case (mode)
        M_SHL: begin
          y_d = {y_q[W-2:0], 1'b0};
          b_d = y_q[W-1];
        end
        M_SHR: begin
          y_d = {1'b0, y_q[W-1:1]};
          b_d = y_q[0];
        end
        M_ROL: begin
          y_d = {y_q[W-2:0], y_q[W-1]};
          b_d = y_q[W-1];
        end
        M_ASR: begin
          y_d = {y_q[W-1], y_q[W-1:1]};
          b_d = y_q[0];
        end
        default: begin
          y_d = y_q;
          b_d = b_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q <= '0;
      s_q <= '0;
      b_q <= 1'b0;
    end else begin
      y_q <= y_d;
      s_q <= s_d;
      b_q <= b_d;
    end
  end

  assign y = y_q;
  assign s = s_q;
  assign b = b_q;

endmodule

// File: rtl/shift_seq_unit.sv
// Shift/rotate sequencer top: control FSM, mode/count latches, status.
// Ports: clk, rst, x, on, n, start, abort -> y, s, b, regime, active, done.
module shift_seq_unit
  import shift_seq_unit_pkg::*;
#(
  parameter  int W  = 8,
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic [1:0]    on,
  input  logic [SW-1:0] n,
  input  logic          start,
  input  logic          abort,
  output logic [W-1:0]  y,
  output logic [SW-1:0] s,
  output logic          b,
  output logic [1:0]    regime,
  output logic          active,
  output logic          done
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [SW-1:0] n_q, n_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          load_en, step_en, last;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    load_en = 1'b0;
    step_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = mode_e'(on);
          n_d     = n;
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (n_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          step_en = 1'b1;
          if (last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // status flops track the state being entered
    active_d = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mode_q   <= M_SHL;
      n_q      <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      n_q      <= n_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  shift_seq_unit_dp #(
    .W  (W),
    .SW (SW)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load_en (load_en),
    .step_en (step_en),
    .mode    (mode_q),
    .x       (x),
    .n       (n_q),
    .y       (y),
    .s       (s),
    .b       (b),
    .last    (last)
  );

  assign regime = state_q;
  assign active = active_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit (W=8).
// Expected per-cycle outputs are queued at start and popped each cycle.
module tb_shift_seq_unit;
  import shift_seq_unit_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] x_i;
  logic [1:0] on_i;
  logic [2:0] n_i;
  logic       start;
  logic       abort;
  logic [7:0] y;
  logic [2:0] s;
  logic       b;
  logic [1:0] regime;
  logic       active;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] y;
    logic [2:0] s;
    logic       b;
    logic [1:0] r;
    logic       act;
    logic       dn;
  } exp_t;

  exp_t q[$];

  logic [7:0] m_y;
  logic [2:0] m_s;
  logic       m_b;

  shift_seq_unit #(.W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x_i),
    .on     (on_i),
    .n      (n_i),
    .start  (start),
    .abort  (abort),
    .y      (y),
    .s      (s),
    .b      (b),
    .regime (regime),
    .active (active),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [1:0] r, input logic act,
                               input logic dn);
    exp_t e;
    e.y   = m_y;
    e.s   = m_s;
    e.b   = m_b;
    e.r   = r;
    e.act = act;
    e.dn  = dn;
    q.push_back(e);
  endfunction

  function automatic void model_step(input logic [1:0] md);
    case (md)
      2'b00: begin m_b = m_y[7]; m_y = m_y << 1; end
      2'b01: begin m_b = m_y[0]; m_y = m_y >> 1; end
      2'b10: begin m_b = m_y[7]; m_y = {m_y[6:0], m_y[7]}; end
      default: begin m_b = m_y[0]; m_y = 8'($signed(m_y) >>> 1); end
    endcase
    m_s = m_s + 3'd1;
  endfunction

  // ab < 0: no abort; ab = k: abort in the RUN cycle after k steps
  task automatic run(input string tag, input logic [7:0] xv,
                     input logic [1:0] ov, input logic [2:0] nv,
                     input int ab, input bit noise);
    exp_t e;
    bit   aborted;
    int   c;
    x_i   = xv;
    on_i  = ov;
    n_i   = nv;
    start = 1'b1;
    aborted = 1'b0;
    push(2'b01, 1'b1, 1'b0);
    m_y = xv;
    m_s = '0;
    m_b = 1'b0;
    for (int j = 0; j < int'(nv); j++) begin
      push(2'b10, 1'b1, 1'b0);
      if (ab == j) begin
        aborted = 1'b1;
        break;
      end
      model_step(ov);
    end
    if (!aborted) push(2'b11, 1'b0, 1'b1);
    push(2'b00, 1'b0, 1'b0);
    c = 0;
    while (q.size() > 0) begin
      tick();
      c++;
      e = q.pop_front();
      if (c == 1) begin
        on_i = ~ov;
        n_i  = ~nv;
      end
      if (c == 2) x_i = ~xv;
      start = noise && (e.r == 2'b10);
      abort = (ab >= 0) && (c == 2 + ab);
      chk({tag, ".y"}, 32'(y), 32'(e.y));
      chk({tag, ".s"}, 32'(s), 32'(e.s));
      chk({tag, ".b"}, 32'(b), 32'(e.b));
      chk({tag, ".regime"}, 32'(regime), 32'(e.r));
      chk({tag, ".active"}, 32'(active), 32'(e.act));
      chk({tag, ".done"}, 32'(done), 32'(e.dn));
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    x_i   = '0;
    on_i  = '0;
    n_i   = '0;
    start = 1'b0;
    abort = 1'b0;
    m_y   = '0;
    m_s   = '0;
    m_b   = 1'b0;
    tick();
    chk("rst0.y", 32'(y), 32'h0);
    chk("rst0.regime", 32'(regime), 32'h0);
    chk("rst0.done", 32'(done), 32'h0);
    rst = 1'b1;
    tick();

    run("shl_a5", 8'hA5, 2'b00, 3'd3, -1, 1'b0);
    run("asr_90", 8'h90, 2'b11, 3'd2, -1, 1'b0);
    run("rol_81", 8'h81, 2'b10, 3'd1, -1, 1'b0);
    run("shr_81", 8'h81, 2'b01, 3'd1, -1, 1'b0);
    run("n0_3c", 8'h3C, 2'b00, 3'd0, -1, 1'b0);
    tick();
    chk("idle_hold.y", 32'(y), 32'h3C);
    run("abort", 8'hA5, 2'b00, 3'd7, 2, 1'b1);
    chk("abort.y_final", 32'(y), 32'h94);
    chk("abort.s_final", 32'(s), 32'h2);
    run("shr_max", 8'hF0, 2'b01, 3'd7, -1, 1'b1);

    x_i   = 8'hA5;
    on_i  = 2'b00;
    n_i   = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid.y", 32'(y), 32'h0);
    chk("rstmid.s", 32'(s), 32'h0);
    chk("rstmid.b", 32'(b), 32'h0);
    chk("rstmid.regime", 32'(regime), 32'h0);
    chk("rstmid.active", 32'(active), 32'h0);
    chk("rstmid.done", 32'(done), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rstpost.regime", 32'(regime), 32'h0);
    chk("rstpost.done", 32'(done), 32'h0);
    m_y = '0;
    m_s = '0;
    m_b = 1'b0;
    run("post_rst", 8'h5A, 2'b10, 3'd4, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
